// File: rtl/lvds_tx_gearbox_if.sv
`default_nettype none
// ============================================================================
//  Module      : lvds_tx_gearbox_if
//  Description : Pixel-side and serializer-side signal bundle of the TX 7:8 gearbox.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lvds_tx_gearbox_if #(
    parameter int LANES = 4
);
    logic [7*LANES-1:0] px_data;
    logic               px_train;
    logic               px_ready;
    logic [4:0]         px_wr_addr;
    logic               tx_reset;
    logic [4:0]         tx_rd_addr;
    logic [2:0]         tx_seq;
    logic [8*LANES-1:0] tx_data;
    logic [7:0]         tx_clk_data;

    // master: pixel source / serializer consumer; slave: the gearbox itself
    modport master (
        output px_data, px_train,
        input  px_ready, px_wr_addr, tx_reset, tx_rd_addr, tx_seq, tx_data, tx_clk_data
    );

    modport slave (
        input  px_data, px_train,
        output px_ready, px_wr_addr, tx_reset, tx_rd_addr, tx_seq, tx_data, tx_clk_data
    );
endinterface
`default_nettype wire

// File: rtl/lvds_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : lvds_tx_gearbox
//  Description : 7:8 TX gearbox; 7-bit px_clk words to 8-bit tx_clk words via a 32-deep FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module lvds_tx_gearbox #(
    parameter int         LANES         = 4,
    parameter logic [6:0] CLK_PATTERN   = 7'b110_0011,
    parameter logic [6:0] TRAIN_PATTERN = 7'b000_1111
) (
    input  wire logic        px_clk,
    input  wire logic        px_reset,
    input  wire logic        tx_clk,
    lvds_tx_gearbox_if.slave bus
);
    // Clock lane is stored as an extra lane at the top of every FIFO word.
    localparam int         c_word_w   = 7 * (LANES + 1);
    localparam int         c_out_w    = 8 * (LANES + 1);
    localparam logic [2:0] c_last_seq = 3'd6;

    logic [c_word_w-1:0] r_mem [0:31];
    logic [4:0]          r_wr_addr;
    logic [c_word_w-1:0] w_wr_word;

    logic [3:0]          r_tx_rst_sync;
    logic                w_tx_reset;
    logic [3:0]          r_rdy_sync;

    logic [4:0]          r_rd_addr;
    logic [4:0]          w_rd_addr_nxt;
    logic [2:0]          r_seq;
    logic [c_word_w-1:0] w_cur;
    logic [c_word_w-1:0] w_nxt;
    logic [c_out_w-1:0]  w_tx_word;
    logic [c_out_w-1:0]  r_tx_word;

    // ---------------- write side (px_clk) ----------------
    assign w_wr_word = {CLK_PATTERN, bus.px_train ? {LANES{TRAIN_PATTERN}} : bus.px_data};

    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) begin
            r_wr_addr <= '0;
        end else begin
            r_wr_addr <= r_wr_addr + 5'd1;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!px_reset) begin
            r_mem[r_wr_addr] <= w_wr_word;
        end
    end

    // ---------------- reset crossing ----------------
    always_ff @(posedge tx_clk or posedge px_reset) begin
        if (px_reset) begin
            r_tx_rst_sync <= 4'hF;
        end else begin
            r_tx_rst_sync <= {r_tx_rst_sync[2:0], 1'b0};
        end
    end

    assign w_tx_reset = r_tx_rst_sync[3];

    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) begin
            r_rdy_sync <= '0;
        end else begin
            r_rdy_sync <= {r_rdy_sync[2:0], ~w_tx_reset};
        end
    end

    // ---------------- read side (tx_clk) ----------------
    // Asynchronous reads across domains are safe: the read pointer trails the
    // write pointer by a fixed 4..8 words because both clocks share one MMCM.
    assign w_rd_addr_nxt = r_rd_addr + 5'd1;
    assign w_cur         = r_mem[r_rd_addr];
    assign w_nxt         = r_mem[w_rd_addr_nxt];

    for (genvar l = 0; l <= LANES; l++) begin : g_lane
        logic [13:0] w_pair;
        assign w_pair              = {w_nxt[7*l +: 7], w_cur[7*l +: 7]};
        assign w_tx_word[8*l +: 8] = 8'(w_pair >> r_seq);
    end

    always_ff @(posedge tx_clk or posedge px_reset) begin
        if (px_reset) begin
            r_rd_addr <= '0;
            r_seq     <= '0;
            r_tx_word <= '0;
        end else if (w_tx_reset) begin
            r_rd_addr <= '0;
            r_seq     <= '0;
            r_tx_word <= '0;
        end else begin
            r_tx_word <= w_tx_word;
            // Phase 6 finishes word N+1 entirely, so the next phase starts at N+2.
            if (r_seq == c_last_seq) begin
                r_seq     <= '0;
                r_rd_addr <= r_rd_addr + 5'd2;
            end else begin
                r_seq     <= r_seq + 3'd1;
                r_rd_addr <= w_rd_addr_nxt;
            end
        end
    end

    assign bus.px_ready    = r_rdy_sync[3];
    assign bus.px_wr_addr  = r_wr_addr;
    assign bus.tx_reset    = w_tx_reset;
    assign bus.tx_rd_addr  = r_rd_addr;
    assign bus.tx_seq      = r_seq;
    assign bus.tx_data     = r_tx_word[8*LANES-1:0];
    assign bus.tx_clk_data = r_tx_word[8*LANES +: 8];

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lvds_tx_gearbox
//  Description : Self-checking bench for lvds_tx_gearbox (phase table + stream scoreboard).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_tx_gearbox;
    localparam int         LANES = 4;
    localparam int         W     = 7 * (LANES + 1);
    localparam logic [6:0] CLKP  = 7'b110_0011;
    localparam logic [6:0] TRNP  = 7'b000_1111;

    typedef struct {
        bit         train;
        logic [6:0] lane_in;
        logic [2:0] phase;
        logic [7:0] clk_word;
        logic [7:0] lane_word;
    } vec_t;

    logic px_clk   = 1'b0;
    logic tx_clk   = 1'b0;
    logic px_reset = 1'b1;
    logic [7*LANES-1:0] drv_data  = '0;
    logic               drv_train = 1'b0;

    // tx_clk at exactly 7/8 of px_clk, phase-locked from time 0
    always #7 px_clk = ~px_clk;
    always #8 tx_clk = ~tx_clk;

    lvds_tx_gearbox_if #(.LANES(LANES)) bus ();
    assign bus.px_data  = drv_data;
    assign bus.px_train = drv_train;

    lvds_tx_gearbox #(
        .LANES        (LANES),
        .CLK_PATTERN  (CLKP),
        .TRAIN_PATTERN(TRNP)
    ) dut (
        .px_clk  (px_clk),
        .px_reset(px_reset),
        .tx_clk  (tx_clk),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  acc [LANES+1];
    int nbits    = 0;
    int tx_cnt   = 0;
    int wr_count = 0;
    int wr_wraps = 0;
    int rd_wraps = 0;
    logic [4:0] prev_wr = '0;
    logic [4:0] prev_rd = '0;
    int seqv = 0;
    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int l = 0; l <= LANES; l++) acc[l] = '0;
        nbits    = 0;
        tx_cnt   = 0;
        wr_count = 0;
        prev_wr  = '0;
        prev_rd  = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_px_wr_addr"}, bus.px_wr_addr, 0);
        check({tag, "_px_ready"},   bus.px_ready, 0);
        check({tag, "_tx_reset"},   bus.tx_reset, 1);
        check({tag, "_tx_rd_addr"}, bus.tx_rd_addr, 0);
        check({tag, "_tx_seq"},     bus.tx_seq, 0);
        check({tag, "_tx_data"},    bus.tx_data, 0);
        check({tag, "_tx_clk_data"}, bus.tx_clk_data, 0);
    endtask

    task automatic run_inc(input int n, input bit train);
        for (int k = 0; k < n; k++) begin
            @(negedge px_clk);
            drv_train = train;
            for (int l = 0; l < LANES; l++) drv_data[7*l +: 7] = 7'(seqv + 13 * l);
            seqv++;
        end
    endtask

    // Model of the words the gearbox must write: one per px_clk out of reset.
    always @(posedge px_clk) begin
        if (!px_reset) begin
            exp_q.push_back({CLKP, drv_train ? {LANES{TRNP}} : drv_data});
            wr_count++;
        end
    end

    always @(negedge px_clk) begin
        if (!px_reset) begin
            check("px_wr_addr", bus.px_wr_addr, wr_count % 32);
            if (bus.px_wr_addr < prev_wr) wr_wraps++;
            prev_wr = bus.px_wr_addr;
        end
    end

    always @(posedge tx_clk) begin
        if (px_reset) tx_cnt = 0;
        else tx_cnt++;
    end

    // Pointer model and LSB-first regrouping of the 8-bit stream into 7-bit words.
    always @(negedge tx_clk) begin
        int k;
        logic [W-1:0] got;
        if (!px_reset && tx_cnt >= 4) begin
            k = tx_cnt - 4;
            check("tx_seq", bus.tx_seq, k % 7);
            check("tx_rd_addr", bus.tx_rd_addr, (8 * (k / 7) + k % 7) % 32);
            if (bus.tx_rd_addr < prev_rd) rd_wraps++;
            prev_rd = bus.tx_rd_addr;
        end
        if (!px_reset && tx_cnt >= 5) begin
            for (int l = 0; l < LANES; l++) acc[l] |= 32'(bus.tx_data[8*l +: 8]) << nbits;
            acc[LANES] |= 32'(bus.tx_clk_data) << nbits;
            nbits += 8;
            while (nbits >= 7) begin
                for (int l = 0; l <= LANES; l++) begin
                    got[7*l +: 7] = acc[l][6:0];
                    acc[l]        = acc[l] >> 7;
                end
                nbits -= 7;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_underflow got=%h exp=<none> t=%0t", got, $time);
                end else begin
                    check("stream_word", got, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        bit synced;

        // Expected words at each phase: ({w,w} >> phase)[7:0]
        tbl[0]  = '{1'b0, 7'h55, 3'd0, 8'hE3, 8'hD5};
        tbl[1]  = '{1'b0, 7'h55, 3'd1, 8'hF1, 8'h6A};
        tbl[2]  = '{1'b0, 7'h55, 3'd2, 8'h78, 8'hB5};
        tbl[3]  = '{1'b0, 7'h55, 3'd3, 8'h3C, 8'h5A};
        tbl[4]  = '{1'b0, 7'h55, 3'd4, 8'h1E, 8'hAD};
        tbl[5]  = '{1'b0, 7'h55, 3'd5, 8'h8F, 8'h56};
        tbl[6]  = '{1'b0, 7'h55, 3'd6, 8'hC7, 8'hAB};
        tbl[7]  = '{1'b1, 7'h55, 3'd0, 8'hE3, 8'h8F};
        tbl[8]  = '{1'b1, 7'h55, 3'd1, 8'hF1, 8'hC7};
        tbl[9]  = '{1'b1, 7'h55, 3'd2, 8'h78, 8'hE3};
        tbl[10] = '{1'b1, 7'h55, 3'd3, 8'h3C, 8'hF1};
        tbl[11] = '{1'b1, 7'h55, 3'd4, 8'h1E, 8'h78};
        tbl[12] = '{1'b1, 7'h55, 3'd5, 8'h8F, 8'h3C};
        tbl[13] = '{1'b1, 7'h55, 3'd6, 8'hC7, 8'h1E};
        clear_model();

        // Reset state, then reset release sequencing
        repeat (3) @(negedge px_clk);
        check_reset_state("por");
        #2 px_reset = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge tx_clk);
            check("rel_tx_reset", bus.tx_reset, (tx_cnt < 4) ? 1 : 0);
            if (tx_cnt < 5) check("rel_tx_data", bus.tx_data, 0);
            if (tx_cnt >= 4) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL rel_wait got=no_release exp=tx_cnt>=4");
        end
        check("px_ready_early", bus.px_ready, 0);
        repeat (4) @(posedge px_clk);
        #1 check("px_ready_4clk", bus.px_ready, 1);

        // Incrementing data stream
        run_inc(60, 1'b0);

        // Phase table: constant data, then steady training
        for (int i = 0; i < 14; i++) begin
            if (i % 7 == 0) begin
                @(negedge px_clk);
                drv_train = tbl[i].train;
                drv_data  = {LANES{tbl[i].lane_in}};
                repeat (24) @(negedge px_clk);
                synced = 1'b0;
                for (int j = 0; j < 20 && !synced; j++) begin
                    @(negedge tx_clk);
                    if (bus.tx_seq == 3'd1) synced = 1'b1;
                end
                if (!synced) begin
                    checks++;
                    failures++;
                    $display("FAIL tbl_sync got=no_phase exp=tx_seq==1");
                end
            end else begin
                @(negedge tx_clk);
            end
            check($sformatf("tbl%0d_seq", i), bus.tx_seq, (tbl[i].phase + 1) % 7);
            check($sformatf("tbl%0d_clk", i), bus.tx_clk_data, tbl[i].clk_word);
            for (int l = 0; l < LANES; l++)
                check($sformatf("tbl%0d_lane%0d", i, l), bus.tx_data[8*l +: 8], tbl[i].lane_word);
        end

        // Training burst of exactly 20 words mid-run
        run_inc(30, 1'b0);
        run_inc(20, 1'b1);
        run_inc(40, 1'b0);

        // Pointer wrap over 320 words
        wr_wraps = 0;
        rd_wraps = 0;
        run_inc(320, 1'b0);
        check("wr_wraps_ge9", (wr_wraps >= 9) ? 1 : 0, 1);
        check("rd_wraps_ge9", (rd_wraps >= 9) ? 1 : 0, 1);

        // Mid-stream reset held for 3 px_clk
        run_inc(13, 1'b0);
        #3 px_reset = 1'b1;
        clear_model();
        #1 check_reset_state("mid");
        repeat (3) @(negedge px_clk);
        #2 px_reset = 1'b0;
        run_inc(80, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
